// File: rtl/serial_add_ctrl.sv
// Sequencer that feeds an external serial adder LSB first and assembles a parallel result.
// Optional feature macro: SUBTRACT_EN (adds sub_i and a carry-preset CARRY state for A-B).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef SUBTRACT_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             sa_a_o,
    output logic             sa_b_o,
    output logic             sa_rst_o,
    input  logic             sa_f_i,
    input  logic             sa_cout_i
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CARRY,
        SHIFT,
        DRAIN
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic [WIDTH-2:0] r_cap;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_capNext;
    logic             w_subIn;

`ifdef SUBTRACT_EN
    assign w_subIn = sub_i;
`else
    assign w_subIn = 1'b0;
`endif

    // Adder F lags its input pair by one cycle, so the newest bit always enters at the MSB.
    assign w_capNext = {sa_f_i, r_cap};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_cap   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_a    <= a_i;
                        r_b    <= b_i;
                        r_sub  <= w_subIn;
                        r_idx  <= '0;
                        r_busy <= 1'b1;
`ifdef SUBTRACT_EN
                        r_state <= CARRY;
`else
                        r_state <= SHIFT;
`endif
                    end
                end
                CARRY: r_state <= SHIFT;
                SHIFT: begin
                    if (r_idx != '0)
                        r_cap <= w_capNext[WIDTH-1:1];
                    if (r_idx == LAST_IDX)
                        r_state <= DRAIN;
                    else
                        r_idx <= r_idx + 1'b1;
                end
                DRAIN: begin
                    r_sum   <= w_capNext;
                    r_cout  <= sa_cout_i;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Serial adder drive is a pure decode so the adder sees each bit in the same cycle.
    always_comb begin
        sa_a_o   = 1'b0;
        sa_b_o   = 1'b0;
        sa_rst_o = 1'b0;
        case (r_state)
            IDLE:  sa_rst_o = 1'b1;
            CARRY: begin
                sa_a_o = r_sub;
                sa_b_o = r_sub;
            end
            SHIFT: begin
                sa_a_o = r_a[r_idx];
                sa_b_o = r_b[r_idx] ^ r_sub;
            end
            default: ;
        endcase
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign sum_o  = r_sum;
    assign cout_o = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl with a behavioural serial adder stand-in.
// Honours SUBTRACT_EN when defined.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;
`ifdef SUBTRACT_EN
    localparam int LAT = WIDTH + 3;
`else
    localparam int LAT = WIDTH + 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
`ifdef SUBTRACT_EN
    logic             sub_i = 1'b0;
`endif
    logic             busy_o, done_o, cout_o, sa_a_o, sa_b_o, sa_rst_o;
    logic [WIDTH-1:0] sum_o;
    logic             saF = 1'b0;
    logic             saC = 1'b0;

    int totalChecks = 0;
    int badChecks = 0;
    int doneCount = 0;
    int opsExpected = 0;
    logic [WIDTH-1:0] lastSum = '0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
`ifdef SUBTRACT_EN
        .sub_i     (sub_i),
`endif
        .busy_o    (busy_o),
        .done_o    (done_o),
        .sum_o     (sum_o),
        .cout_o    (cout_o),
        .sa_a_o    (sa_a_o),
        .sa_b_o    (sa_b_o),
        .sa_rst_o  (sa_rst_o),
        .sa_f_i    (saF),
        .sa_cout_i (saC)
    );

    always #5 clk = ~clk;

    // Serial adder stand-in: registered sum bit and carry, synchronous clear.
    always @(posedge clk) begin
        if (sa_rst_o) begin
            saF <= 1'b0;
            saC <= 1'b0;
        end else begin
            saF <= sa_a_o ^ sa_b_o ^ saC;
            saC <= (int'(sa_a_o) + int'(sa_b_o) + int'(saC)) >= 2;
        end
    end

    always @(negedge clk) if (done_o) doneCount++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s, input int midStart, input int midRst);
        logic        effS;
        int          full;
        logic [31:0] fullV;
        logic [WIDTH-1:0] expSum;
        logic        expCout;
        int          doneAt;
        logic        busyOk;
        logic        aborted;
`ifdef SUBTRACT_EN
        effS = s;
        sub_i = s;
`else
        effS = 1'b0;
`endif
        full = effS ? (int'(a) + (1 << WIDTH) - int'(b)) : (int'(a) + int'(b));
        fullV = full;
        expSum = fullV[WIDTH-1:0];
        expCout = fullV[WIDTH];

        a_i = a;
        b_i = b;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i = WIDTH'($urandom);
        b_i = WIDTH'($urandom);
        doneAt = 0;
        busyOk = 1'b1;
        aborted = 1'b0;
        for (int n = 1; n <= LAT + 4 && doneAt == 0 && !aborted; n++) begin
            @(negedge clk);
            if (n == midStart) begin
                start_i = 1'b1;
                a_i = 1;
                b_i = 1;
            end else begin
                start_i = 1'b0;
            end
            if (n == 2) checkOutput("sumHold", 32'(sum_o), 32'(lastSum));
            if (n == midRst) begin
                rst = 1'b1;
                #1;
                checkOutput("rstBusy", 32'(busy_o), 0);
                checkOutput("rstSum", 32'(sum_o), 0);
                checkOutput("rstCout", 32'(cout_o), 0);
                checkOutput("rstSaRst", 32'(sa_rst_o), 1);
                checkOutput("rstDone", 32'(done_o), 0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
            end else if (done_o) begin
                doneAt = n;
            end else if (busy_o !== 1'b1) begin
                busyOk = 1'b0;
            end
        end
        start_i = 1'b0;
        if (aborted) begin
            lastSum = '0;
            for (int n = 0; n < LAT + 2; n++) begin
                @(negedge clk);
                if (done_o) busyOk = 1'b0;
            end
            checkOutput("noDoneAfterRst", 32'(busyOk), 1);
            return;
        end
        opsExpected++;
        checkOutput("latency", doneAt, LAT);
        checkOutput("busyRun", 32'(busyOk), 1);
        checkOutput("busyAtDone", 32'(busy_o), 0);
        checkOutput("sum", 32'(sum_o), 32'(expSum));
        checkOutput("cout", 32'(cout_o), 32'(expCout));
        lastSum = expSum;
    endtask

    initial begin
        #12;
        checkOutput("resetBusy", 32'(busy_o), 0);
        checkOutput("resetDone", 32'(done_o), 0);
        checkOutput("resetSum", 32'(sum_o), 0);
        checkOutput("resetCout", 32'(cout_o), 0);
        checkOutput("resetSaA", 32'(sa_a_o), 0);
        checkOutput("resetSaB", 32'(sa_b_o), 0);
        checkOutput("resetSaRst", 32'(sa_rst_o), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(8'h5A, 8'h3C, 1'b0, 0, 0);
        @(negedge clk);
        applyStimulus(8'hFF, 8'h01, 1'b0, 0, 0);
        applyStimulus(8'h00, 8'h00, 1'b0, 0, 0);
        @(negedge clk);
        applyStimulus(8'h5A, 8'h3C, 1'b0, 3, 0);
        @(negedge clk);
        applyStimulus(8'h5A, 8'h3C, 1'b0, 0, 4);
        applyStimulus(8'h12, 8'h34, 1'b0, 0, 0);
`ifdef SUBTRACT_EN
        applyStimulus(8'h10, 8'h01, 1'b1, 0, 0);
        applyStimulus(8'h01, 8'h02, 1'b1, 0, 0);
        applyStimulus(8'h80, 8'h80, 1'b0, 0, 0);
`endif
        for (int k = 0; k < 24; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 0);
        end
        repeat (3) @(negedge clk);
        checkOutput("doneCount", doneCount, opsExpected);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
